branch_target_predictor: RTL and testbench
==========================================

# branch_target_predictor

Parametrised branch target predictor for the IF stage of the pipelined RISC-V core: a direct-mapped, tagged table of saturating direction counters and stored targets. Supersedes the single-bit prediction table with configurable depth, tag width and counter width, adds separate handling of unconditional jumps, a synchronous whole-table invalidate, and saturating lookup/mispredict statistics. Lookup is combinational in IF; updates arrive from the ID-stage branch resolution.

## Interface
- DATA_W, 64, PC and target width
- IDX_W, 4, index bits; table depth = 2^IDX_W entries
- TAG_W, 8, tag bits stored per entry
- CNT_W, 2, direction counter width (1 = last-outcome, 2 = bimodal, up to 4)
- STAT_W, 32, width of each statistics counter

- clk  in  1  clock, all state updates on rising edge
- arst  in  1  asynchronous reset, active-high
- lookup_en  in  1  IF fetch valid (qualifies statistics only)
- lookup_pc  in  DATA_W  PC being fetched
- pred_taken  out  1  predicted taken (combinational)
- pred_target  out  DATA_W  predicted next PC (combinational)
- upd_valid  in  1  resolved control-flow instruction present in ID
- upd_pc  in  DATA_W  PC of the resolved instruction
- upd_is_jump  in  1  1 = unconditional jump, 0 = conditional branch
- upd_taken  in  1  actual outcome
- upd_target  in  DATA_W  actual taken target
- upd_mispredict  in  1  prediction was wrong (statistics only)
- flush_all  in  1  synchronous invalidate of all entries
- stat_lookups  out  STAT_W  count of cycles with lookup_en=1
- stat_mispredicts  out  STAT_W  count of updates with upd_mispredict=1

## Operation
- Address split: index = pc[IDX_W+1:2], tag = pc[IDX_W+TAG_W+1:IDX_W+2]; pc[1:0] ignored.
- Entry state: valid, tag, counter (CNT_W), target (DATA_W).
- Lookup: hit = valid & tag match at index; pred_taken = hit & counter[CNT_W-1]; pred_target = stored target if pred_taken, else lookup_pc + 4 (mod 2^DATA_W).
- Update, upd_valid=1, hit:
  - jump: counter <= all ones; target <= upd_target.
  - branch taken: counter saturating +1 (stops at 2^CNT_W-1); target <= upd_target.
  - branch not taken: counter saturating -1 (stops at 0); target unchanged.
- Update, miss (invalid or tag mismatch):
  - taken (jump or branch): allocate/replace: valid<=1, tag, target <= upd_target; counter <= all ones for jump, 2^(CNT_W-1) (weakly taken) for branch.
  - not taken: no allocation, existing entry untouched.
- flush_all=1: every valid bit cleared next edge; counters/targets/stats keep values. flush_all and upd_valid same cycle: flush wins, no entry written.
- Statistics: increment by 1 per qualifying cycle, saturate at 2^STAT_W-1, never wrap; unaffected by flush_all.
- CNT_W=1: counter is last outcome; allocation value 1.

## Timing
- Reset (arst=1, asynchronous): all valid, counters, targets, stat counters cleared to 0. While reset and afterwards until first allocation: pred_taken=0, pred_target=lookup_pc+4; stat outputs 0.
- Lookup latency 0 cycles (combinational from lookup_pc and registered table).
- Update written at rising edge where upd_valid=1; visible to lookup from the next cycle. Same-cycle lookup of the entry being updated sees pre-update contents.
- No backpressure; one update per cycle maximum.
- Reset asserted mid-operation discards all in-flight updates for that edge.

## Test plan
- Reset, lookup_pc=0x100 -> pred_taken=0, pred_target=0x104, stat_lookups=0.
- Branch at 0x100 taken to 0x80 (CNT_W=2) -> next cycle lookup 0x100: pred_taken=1, target 0x80; one not-taken update -> pred_taken=0, pred_target=0x104; second taken -> pred_taken=1 again.
- Jump 0x200 -> 0x400, then branch 0x200 not taken once -> counter 3->2, still predicts 0x400; alias 0x200 + 2^(IDX_W+2)=0x240 taken to 0x10 -> replaces entry, 0x200 now misses.
- Same-cycle update and lookup at 0x100 -> lookup shows old prediction, new value next cycle; flush_all with upd_valid -> all entries invalid, update dropped.
- STAT_W=4: 20 lookup_en cycles -> stat_lookups=15 (saturated); 3 mispredict updates -> stat_mispredicts=3; flush_all leaves both unchanged.
- arst asserted between clock edges after populating table -> outputs immediately pred_taken=0, stats 0.

Source files
------------

// File: rtl/branch_target_predictor_if.sv
// Lookup, update, flush and statistics bundle of the branch target predictor.
// The master drives the fetch and resolution side and the slave is the predictor.
interface branch_target_predictor_if #(
   parameter int unsigned DATA_W = 64,
   parameter int unsigned STAT_W = 32
);
   logic              lookup_en;
   logic [DATA_W-1:0] lookup_pc;
   logic              pred_taken;
   logic [DATA_W-1:0] pred_target;
   logic              upd_valid;
   logic [DATA_W-1:0] upd_pc;
   logic              upd_is_jump;
   logic              upd_taken;
   logic [DATA_W-1:0] upd_target;
   logic              upd_mispredict;
   logic              flush_all;
   logic [STAT_W-1:0] stat_lookups;
   logic [STAT_W-1:0] stat_mispredicts;

   modport master (
      output lookup_en, lookup_pc, upd_valid, upd_pc, upd_is_jump, upd_taken, upd_target,
             upd_mispredict, flush_all,
      input  pred_taken, pred_target, stat_lookups, stat_mispredicts
   );

   modport slave (
      input  lookup_en, lookup_pc, upd_valid, upd_pc, upd_is_jump, upd_taken, upd_target,
             upd_mispredict, flush_all,
      output pred_taken, pred_target, stat_lookups, stat_mispredicts
   );
endinterface

// File: rtl/branch_target_predictor.sv
// Direct-mapped tagged branch target table with saturating direction counters,
// combinational lookup, ID-stage updates, whole-table flush and saturating statistics.
module branch_target_predictor #(
   parameter int unsigned DATA_W = 64,
   parameter int unsigned IDX_W  = 4,
   parameter int unsigned TAG_W  = 8,
   parameter int unsigned CNT_W  = 2,
   parameter int unsigned STAT_W = 32
) (
   input logic                     clk,
   input logic                     arst,
   branch_target_predictor_if.slave bus
);
   localparam int unsigned DEPTH = 2 ** IDX_W;
   localparam int unsigned TAG_LO = IDX_W + 2;
   localparam int unsigned TAG_HI = IDX_W + TAG_W + 1;
   localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
   localparam logic [CNT_W-1:0]  CNT_WEAK = CNT_W'(1 << (CNT_W - 1));
   localparam logic [STAT_W-1:0] STAT_MAX = '1;

   logic              r_valid  [DEPTH];
   logic [TAG_W-1:0]  r_tag    [DEPTH];
   logic [CNT_W-1:0]  r_cnt    [DEPTH];
   logic [DATA_W-1:0] r_target [DEPTH];
   logic [STAT_W-1:0] r_stat_lookups;
   logic [STAT_W-1:0] r_stat_mispredicts;

   logic [IDX_W-1:0] w_lk_idx;
   logic [TAG_W-1:0] w_lk_tag;
   logic             w_lk_hit;
   logic [IDX_W-1:0] w_up_idx;
   logic [TAG_W-1:0] w_up_tag;
   logic             w_up_hit;
   logic [CNT_W-1:0] w_up_cnt;
   logic             w_wr_en;
   logic             w_tgt_wr;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic             w_unused;

   assign w_lk_idx = bus.lookup_pc[IDX_W+1:2];
   assign w_lk_tag = bus.lookup_pc[TAG_HI:TAG_LO];
   assign w_lk_hit = r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag);

   // Lookup reads only the registered table, so a same-cycle update is not visible yet.
   assign bus.pred_taken  = w_lk_hit && r_cnt[w_lk_idx][CNT_W-1];
   assign bus.pred_target = bus.pred_taken ? r_target[w_lk_idx] : bus.lookup_pc + DATA_W'(4);

   assign w_up_idx = bus.upd_pc[IDX_W+1:2];
   assign w_up_tag = bus.upd_pc[TAG_HI:TAG_LO];
   assign w_up_hit = r_valid[w_up_idx] && (r_tag[w_up_idx] == w_up_tag);
   assign w_up_cnt = r_cnt[w_up_idx];

   assign w_unused = ^{bus.upd_pc[1:0], bus.upd_pc[DATA_W-1:TAG_HI+1]};

   always_comb begin
      w_wr_en   = 1'b0;
      w_tgt_wr  = 1'b0;
      w_cnt_nxt = w_up_cnt;
      if (bus.upd_valid && !bus.flush_all) begin
         if (w_up_hit) begin
            w_wr_en = 1'b1;
            if (bus.upd_is_jump) begin
               w_cnt_nxt = CNT_MAX;
               w_tgt_wr  = 1'b1;
            end else if (bus.upd_taken) begin
               w_cnt_nxt = (w_up_cnt == CNT_MAX) ? w_up_cnt : w_up_cnt + CNT_W'(1);
               w_tgt_wr  = 1'b1;
            end else begin
               w_cnt_nxt = (w_up_cnt == '0) ? w_up_cnt : w_up_cnt - CNT_W'(1);
            end
         end else if (bus.upd_is_jump || bus.upd_taken) begin
            // Miss on a taken transfer replaces whatever sits at this index.
            w_wr_en   = 1'b1;
            w_tgt_wr  = 1'b1;
            w_cnt_nxt = bus.upd_is_jump ? CNT_MAX : CNT_WEAK;
         end
      end
   end

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_valid[i]  <= 1'b0;
            r_tag[i]    <= '0;
            r_cnt[i]    <= '0;
            r_target[i] <= '0;
         end
      end else if (bus.flush_all) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_valid[i] <= 1'b0;
         end
      end else if (w_wr_en) begin
         r_valid[w_up_idx] <= 1'b1;
         r_tag[w_up_idx]   <= w_up_tag;
         r_cnt[w_up_idx]   <= w_cnt_nxt;
         if (w_tgt_wr) begin
            r_target[w_up_idx] <= bus.upd_target;
         end
      end
   end

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         r_stat_lookups     <= '0;
         r_stat_mispredicts <= '0;
      end else begin
         if (bus.lookup_en && (r_stat_lookups != STAT_MAX)) begin
            r_stat_lookups <= r_stat_lookups + STAT_W'(1);
         end
         if (bus.upd_valid && bus.upd_mispredict && (r_stat_mispredicts != STAT_MAX)) begin
            r_stat_mispredicts <= r_stat_mispredicts + STAT_W'(1);
         end
      end
   end

   assign bus.stat_lookups     = r_stat_lookups;
   assign bus.stat_mispredicts = r_stat_mispredicts;
endmodule

// File: tb/tb_branch_target_predictor.sv
// Scoreboard bench: the driver pushes expected outputs from a behavioural table model,
// and a negedge monitor pops and compares them against the predictor.
module tb_branch_target_predictor;
   localparam int unsigned DATA_W = 64;
   localparam int unsigned IDX_W  = 4;
   localparam int unsigned TAG_W  = 8;
   localparam int unsigned CNT_W  = 2;
   localparam int unsigned STAT_W = 4;
   localparam int DEPTH    = 1 << IDX_W;
   localparam int CNT_TOP  = (1 << CNT_W) - 1;
   localparam int CNT_HALF = 1 << (CNT_W - 1);
   localparam int STAT_TOP = (1 << STAT_W) - 1;

   typedef struct {
      string       name;
      bit          taken;
      logic [63:0] target;
      int          lookups;
      int          mispredicts;
   } exp_t;

   logic clk;
   logic arst;
   exp_t sb_q[$];
   int   n_vec;
   int   n_err;

   // Reference table
   bit          m_valid [DEPTH];
   int          m_tag   [DEPTH];
   int          m_cnt   [DEPTH];
   logic [63:0] m_tgt   [DEPTH];
   int          m_lookups;
   int          m_mispredicts;

   branch_target_predictor_if #(.DATA_W(DATA_W), .STAT_W(STAT_W)) bus ();

   branch_target_predictor #(
      .DATA_W (DATA_W),
      .IDX_W  (IDX_W),
      .TAG_W  (TAG_W),
      .CNT_W  (CNT_W),
      .STAT_W (STAT_W)
   ) dut (
      .clk  (clk),
      .arst (arst),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int pc_idx(input logic [63:0] pc);
      return int'((pc >> 2) % DEPTH);
   endfunction

   function automatic int pc_tag(input logic [63:0] pc);
      return int'((pc >> (IDX_W + 2)) % (1 << TAG_W));
   endfunction

   task automatic model_reset();
      for (int i = 0; i < DEPTH; i++) begin
         m_valid[i] = 1'b0;
         m_tag[i]   = 0;
         m_cnt[i]   = 0;
         m_tgt[i]   = '0;
      end
      m_lookups     = 0;
      m_mispredicts = 0;
   endtask

   // One clock cycle: apply inputs after the edge, queue what the DUT must show now,
   // then advance the model to the state it must hold after the next edge.
   task automatic step(input string name, input bit rst, input bit le, input logic [63:0] lpc,
                       input bit uv, input logic [63:0] upc, input bit uj, input bit ut,
                       input logic [63:0] utg, input bit um, input bit fl);
      exp_t e;
      int   li, ui;
      bit   hit;
      @(posedge clk);
      #1;
      arst               = rst;
      bus.lookup_en      = le;
      bus.lookup_pc      = lpc;
      bus.upd_valid      = uv;
      bus.upd_pc         = upc;
      bus.upd_is_jump    = uj;
      bus.upd_taken      = ut;
      bus.upd_target     = utg;
      bus.upd_mispredict = um;
      bus.flush_all      = fl;
      if (rst) model_reset();
      li = pc_idx(lpc);
      e.name        = name;
      e.taken       = m_valid[li] && (m_tag[li] == pc_tag(lpc)) && (m_cnt[li] >= CNT_HALF);
      e.target      = e.taken ? m_tgt[li] : lpc + 64'd4;
      e.lookups     = m_lookups;
      e.mispredicts = m_mispredicts;
      sb_q.push_back(e);
      if (!rst) begin
         if (le && m_lookups < STAT_TOP) m_lookups++;
         if (uv && um && m_mispredicts < STAT_TOP) m_mispredicts++;
         if (fl) begin
            for (int i = 0; i < DEPTH; i++) m_valid[i] = 1'b0;
         end else if (uv) begin
            ui  = pc_idx(upc);
            hit = m_valid[ui] && (m_tag[ui] == pc_tag(upc));
            if (hit) begin
               if (uj) begin
                  m_cnt[ui] = CNT_TOP;
                  m_tgt[ui] = utg;
               end else if (ut) begin
                  m_cnt[ui] = (m_cnt[ui] + 1 > CNT_TOP) ? CNT_TOP : m_cnt[ui] + 1;
                  m_tgt[ui] = utg;
               end else begin
                  m_cnt[ui] = (m_cnt[ui] > 0) ? m_cnt[ui] - 1 : 0;
               end
            end else if (uj || ut) begin
               m_valid[ui] = 1'b1;
               m_tag[ui]   = pc_tag(upc);
               m_tgt[ui]   = utg;
               m_cnt[ui]   = uj ? CNT_TOP : CNT_HALF;
            end
         end
      end
   endtask

   task automatic look(input string name, input logic [63:0] lpc);
      step(name, 0, 1, lpc, 0, '0, 0, 0, '0, 0, 0);
   endtask

   task automatic upd(input string name, input logic [63:0] lpc, input logic [63:0] upc,
                      input bit uj, input bit ut, input logic [63:0] utg);
      step(name, 0, 1, lpc, 1, upc, uj, ut, utg, 0, 0);
   endtask

   function automatic logic [63:0] rand_pc();
      logic [63:0] p;
      p       = {$urandom(), $urandom()};
      p[13:6] = 8'($urandom_range(0, 3));
      p[5:2]  = 4'($urandom_range(0, 3));
      return p;
   endfunction

   always @(negedge clk) begin
      exp_t e;
      if (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         n_vec++;
         if (bus.pred_taken !== e.taken) begin
            n_err++;
            $display("FAIL %s pred_taken got %0b want %0b", e.name, bus.pred_taken, e.taken);
         end
         if (bus.pred_target !== e.target) begin
            n_err++;
            $display("FAIL %s pred_target got %h want %h", e.name, bus.pred_target, e.target);
         end
         if (bus.stat_lookups !== STAT_W'(e.lookups)) begin
            n_err++;
            $display("FAIL %s stat_lookups got %0d want %0d", e.name, bus.stat_lookups,
                     e.lookups);
         end
         if (bus.stat_mispredicts !== STAT_W'(e.mispredicts)) begin
            n_err++;
            $display("FAIL %s stat_mispredicts got %0d want %0d", e.name, bus.stat_mispredicts,
                     e.mispredicts);
         end
      end
   end

   initial begin
      n_vec = 0;
      n_err = 0;
      arst  = 1'b1;
      bus.lookup_en      = 1'b0;
      bus.lookup_pc      = 64'h100;
      bus.upd_valid      = 1'b0;
      bus.upd_pc         = '0;
      bus.upd_is_jump    = 1'b0;
      bus.upd_taken      = 1'b0;
      bus.upd_target     = '0;
      bus.upd_mispredict = 1'b0;
      bus.flush_all      = 1'b0;
      model_reset();

      step("reset", 1, 1, 64'h100, 0, '0, 0, 0, '0, 0, 0);
      step("reset_hold", 1, 1, 64'h100, 1, 64'h100, 1, 1, 64'h80, 1, 0);
      look("post_reset", 64'h100);

      // Direction counter walk at 0x100 including same-cycle update and lookup
      upd("br_alloc", 64'h100, 64'h100, 0, 1, 64'h80);
      upd("same_cycle_nt", 64'h100, 64'h100, 0, 0, '0);
      upd("weak_nt_retaken", 64'h100, 64'h100, 0, 1, 64'h80);
      look("retaken", 64'h100);

      // Jump, branch not-taken softening, then aliasing replacement
      upd("jump_alloc", 64'h200, 64'h200, 1, 1, 64'h400);
      upd("jump_hit_nt", 64'h200, 64'h200, 0, 0, '0);
      upd("alias_replace", 64'h200, 64'h240, 0, 1, 64'h10);
      look("alias_new", 64'h240);
      look("alias_old_miss", 64'h200);

      // Flush with a simultaneous update drops the update
      step("flush_upd", 0, 1, 64'h240, 1, 64'h300, 1, 1, 64'h500, 0, 1);
      look("flushed_240", 64'h240);
      look("flushed_300", 64'h300);
      upd("nt_miss_noalloc", 64'h300, 64'h300, 0, 0, 64'h900);
      look("nt_miss_check", 64'h300);

      // Statistics saturation and flush independence
      step("stat_reset", 1, 0, 64'h0, 0, '0, 0, 0, '0, 0, 0);
      for (int i = 0; i < 20; i++) look("stat_lookups", 64'(i * 4));
      for (int i = 0; i < 3; i++) step("stat_misp", 0, 0, 64'h0, 1, 64'h44, 0, 0, '0, 1, 0);
      step("stat_flush", 0, 0, 64'h0, 0, '0, 0, 0, '0, 0, 1);
      look("stat_after_flush", 64'h0);

      // Random traffic over a small set of aliasing PCs
      for (int i = 0; i < 400; i++) begin
         step("random", 0, 1'($urandom_range(0, 1)), rand_pc(), 1'($urandom_range(0, 3) != 0),
              rand_pc(), 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
              {$urandom(), $urandom()}, 1'($urandom_range(0, 1)),
              $urandom_range(0, 29) == 0);
      end

      // Asynchronous reset between edges on a populated table
      upd("pre_areset", 64'h100, 64'h100, 1, 1, 64'h4000);
      look("pre_areset_hit", 64'h100);
      step("areset_mid", 1, 1, 64'h100, 1, 64'h100, 1, 1, 64'h8000, 1, 0);
      look("after_areset", 64'h100);

      repeat (3) @(posedge clk);
      if (sb_q.size() != 0) begin
         n_err++;
         $display("FAIL drain queue_left got %0d want 0", sb_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
